// File: rtl/double_to_int_arbiter.sv
// ---------------------------------------------------------------------------
// double_to_int_arbiter
//
// Shares one pipelined double->int64 converter between NUM_REQ requesters.
// Operands are granted one per cycle, and each operand is tracked by a
// {valid, index} tag that travels alongside it through a LATENCY-deep tag
// pipeline. When a tag reaches the last stage, the converter output is
// captured into that requester's result register. The register holds the
// value until the requester acknowledges it.
//
// Handshakes (both directions use the same rule):
//   A transfer happens on a rising edge where the strobe and the ack are both
//   high. The strobe side may drop its strobe at any time before the
//   transfer, and nothing changes. The ack side never depends on a transfer
//   having already happened in the same cycle.
//     operand side : req_stb[i] (valid) / req_ack[i] (ready, one-hot grant)
//     result side  : res_stb[i] (valid) / res_ack[i] (ready)
//
// Parameters:
//   NUM_REQ  number of requesters (2..8)
//   LATENCY  converter latency in clk edges (>= 1)
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   req_a      NUM_REQ packed 64-bit operands, slice i = [64*i +: 64]
//   req_stb    per-requester operand valid
//   req_ack    one-hot grant (combinational)
//   res_z      NUM_REQ packed 64-bit held results
//   res_stb    per-requester result valid
//   res_ack    per-requester result consume
//   conv_a     registered operand to the shared converter
//   conv_z     converter result
//   dbg_state  per-requester FSM state, 2 bits each (0 IDLE, 1 BUSY, 2 DONE)
//
// Build option:
//   DOUBLE_TO_INT_ARBITER_FIXED_PRIORITY_EN
//     Defined: the lowest-index eligible requester always wins, and there is
//     no round-robin pointer.
//     Undefined (default): round-robin starting from rr_q.
// ---------------------------------------------------------------------------
module double_to_int_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ*64-1:0]  req_a,
    input  logic [NUM_REQ-1:0]     req_stb,
    output logic [NUM_REQ-1:0]     req_ack,
    output logic [NUM_REQ*64-1:0]  res_z,
    output logic [NUM_REQ-1:0]     res_stb,
    input  logic [NUM_REQ-1:0]     res_ack,
    output logic [63:0]            conv_a,
    input  logic [63:0]            conv_z,
    output logic [2*NUM_REQ-1:0]   dbg_state
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } req_state_e;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } tag_t;

    req_state_e            state_q [NUM_REQ];
    req_state_e            state_d [NUM_REQ];
    tag_t                  tag_q   [LATENCY];
    logic [63:0]           conv_a_q;
    logic [NUM_REQ*64-1:0] res_z_q;

    logic [NUM_REQ-1:0]    elig;
    logic                  gnt_vld;
    logic [IDX_W-1:0]      gnt_idx;
    logic                  cap_vld;
    logic [IDX_W-1:0]      cap_idx;
    logic [IDX_W:0]        cand_w;
    logic [IDX_W-1:0]      cand;

`ifndef DOUBLE_TO_INT_ARBITER_FIXED_PRIORITY_EN
    logic [IDX_W-1:0]      rr_q;
    logic [IDX_W-1:0]      rr_d;
`endif

    // A requester may only be granted while its FSM is IDLE. This keeps at
    // most one operation per requester in flight, so a capture never
    // overwrites a result that has not been consumed yet.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = req_stb[i] && (state_q[i] == ST_IDLE);
        end
    end

    // The candidate search visits every index exactly once. In round-robin
    // mode it starts at rr_q and wraps modulo NUM_REQ. The extra bit in
    // cand_w holds the unwrapped sum. No grant is issued while rst is high.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand_w  = '0;
        cand    = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
`ifdef DOUBLE_TO_INT_ARBITER_FIXED_PRIORITY_EN
            cand_w = (IDX_W+1)'(off);
`else
            cand_w = {1'b0, rr_q} + (IDX_W+1)'(off);
            if (cand_w >= (IDX_W+1)'(NUM_REQ)) begin
                cand_w = cand_w - (IDX_W+1)'(NUM_REQ);
            end
`endif
            cand = cand_w[IDX_W-1:0];
            if (!gnt_vld && !rst && elig[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        req_ack = '0;
        if (gnt_vld) begin
            req_ack[gnt_idx] = 1'b1;
        end
    end

`ifndef DOUBLE_TO_INT_ARBITER_FIXED_PRIORITY_EN
    always_comb begin
        rr_d = rr_q;
        if (gnt_vld) begin
            rr_d = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    // The last tag stage names the requester whose result is on conv_z at
    // this edge.
    assign cap_vld = tag_q[LATENCY-1].valid;
    assign cap_idx = tag_q[LATENCY-1].idx;

    // Per-requester FSM. BUSY only leaves through a capture, and only BUSY
    // requesters have valid tags, so capture and ack never overlap.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                ST_IDLE: if (gnt_vld && gnt_idx == IDX_W'(i)) state_d[i] = ST_BUSY;
                ST_BUSY: if (cap_vld && cap_idx == IDX_W'(i)) state_d[i] = ST_DONE;
                ST_DONE: if (res_ack[i])                      state_d[i] = ST_IDLE;
                default:                                      state_d[i] = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                state_q[i] <= ST_IDLE;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                state_q[i] <= state_d[i];
            end
        end
    end

    // The tag pipeline shifts every cycle. A cycle without a grant inserts a
    // bubble, so results emerging after a reset are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < LATENCY; j++) begin
                tag_q[j] <= '0;
            end
        end else begin
            tag_q[0] <= {gnt_vld, gnt_idx};
            for (int j = 1; j < LATENCY; j++) begin
                tag_q[j] <= tag_q[j-1];
            end
        end
    end

    // conv_a holds its value when there is no grant. A result slice keeps its
    // value after being acked and changes only on the next capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conv_a_q <= '0;
            res_z_q  <= '0;
        end else begin
            if (gnt_vld) begin
                conv_a_q <= req_a[gnt_idx*64 +: 64];
            end
            if (cap_vld) begin
                res_z_q[cap_idx*64 +: 64] <= conv_z;
            end
        end
    end

    always_comb begin
        res_stb   = '0;
        dbg_state = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            res_stb[i]          = (state_q[i] == ST_DONE);
            dbg_state[2*i +: 2] = state_q[i];
        end
    end

    assign conv_a = conv_a_q;
    assign res_z  = res_z_q;

endmodule

// File: tb/tb_double_to_int_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for double_to_int_arbiter.
//
// The bench contains a behavioural converter: d2i() applied after a delay of
// LAT edges. The reference model tracks each requester as idle, busy or done,
// holds a queue of in-flight operands with cycles remaining, and keeps a
// priority pointer. Each scenario task drives inputs, advances one clock with
// step(), and compares the DUT against the model or against constants.
// ---------------------------------------------------------------------------
module tb_double_to_int_arbiter;

    localparam int NR  = 4;
    localparam int LAT = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR*64-1:0]  req_a   = '0;
    logic [NR-1:0]     req_stb = '0;
    logic [NR-1:0]     req_ack;
    logic [NR*64-1:0]  res_z;
    logic [NR-1:0]     res_stb;
    logic [NR-1:0]     res_ack = '0;
    logic [63:0]       conv_a;
    logic [63:0]       conv_z;
    logic [2*NR-1:0]   dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    double_to_int_arbiter #(.NUM_REQ(NR), .LATENCY(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_a     (req_a),
        .req_stb   (req_stb),
        .req_ack   (req_ack),
        .res_z     (res_z),
        .res_stb   (res_stb),
        .res_ack   (res_ack),
        .conv_a    (conv_a),
        .conv_z    (conv_z),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- converter model ----------------
    // Truncates toward zero and saturates out-of-range values.
    function automatic logic [63:0] d2i(input logic [63:0] a);
        int          e;
        logic [63:0] man;
        logic [63:0] mag;
        e   = int'(a[62:52]) - 1023;
        man = {11'd0, 1'b1, a[51:0]};
        if (e < 0) return 64'd0;
        if (e >= 63) return a[63] ? 64'h8000000000000000 : 64'h7FFFFFFFFFFFFFFF;
        if (e >= 52) mag = man << (e - 52);
        else         mag = man >> (52 - e);
        return a[63] ? (~mag + 64'd1) : mag;
    endfunction

    logic [63:0] pipe [0:LAT];
    always @(posedge clk) begin
        pipe[1] <= d2i(conv_a);
        for (int j = 2; j < LAT; j++) pipe[j] <= pipe[j-1];
    end
    assign conv_z = (LAT == 1) ? d2i(conv_a) : pipe[LAT-1];

    function automatic logic [63:0] rand_double();
        logic [63:0] m;
        logic [10:0] ex;
        m  = {$urandom(), $urandom()};
        ex = 11'(1021 + $urandom_range(0, 60));
        return {1'($urandom_range(0, 1)), ex, m[51:0]};
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        int          idx;
        logic [63:0] op;
        int          cnt;
    } fl_t;

    int          m_st [NR];     // 0 idle, 1 busy, 2 done
    logic [63:0] m_res [NR];
    logic [63:0] m_conv_a;
    int          m_rr;
    fl_t         exp_q [$];

    logic [NR-1:0] exp_ack;
    logic [NR-1:0] obs_ack;

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_st[i]  = 0;
            m_res[i] = '0;
        end
        m_conv_a = '0;
        m_rr     = 0;
        exp_q.delete();
    endtask

    function automatic logic [NR-1:0] model_grant();
        logic [NR-1:0] g;
        int            i;
        g = '0;
        if (rst) return g;
        for (int off = 0; off < NR; off++) begin
`ifdef DOUBLE_TO_INT_ARBITER_FIXED_PRIORITY_EN
            i = off;
`else
            i = (m_rr + off) % NR;
`endif
            if (req_stb[i] && m_st[i] == 0) begin
                g[i] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    task automatic model_edge(input logic [NR-1:0] g);
        fl_t e;
        if (rst) begin
            model_reset();
            return;
        end
        for (int i = 0; i < NR; i++)
            if (m_st[i] == 2 && res_ack[i]) m_st[i] = 0;
        for (int j = 0; j < exp_q.size(); j++)
            exp_q[j].cnt = exp_q[j].cnt - 1;
        while (exp_q.size() > 0 && exp_q[0].cnt == 0) begin
            e = exp_q.pop_front();
            m_res[e.idx] = d2i(e.op);
            m_st[e.idx]  = 2;
        end
        for (int i = 0; i < NR; i++) begin
            if (g[i]) begin
                e.idx = i;
                e.op  = req_a[i*64 +: 64];
                e.cnt = LAT;
                exp_q.push_back(e);
                m_st[i]  = 1;
                m_conv_a = e.op;
                m_rr     = (i + 1) % NR;
            end
        end
    endtask

    function automatic logic [NR-1:0] exp_stb();
        logic [NR-1:0] s;
        for (int i = 0; i < NR; i++) s[i] = (m_st[i] == 2);
        return s;
    endfunction

    function automatic logic [NR*64-1:0] exp_z();
        logic [NR*64-1:0] z;
        for (int i = 0; i < NR; i++) z[i*64 +: 64] = m_res[i];
        return z;
    endfunction

    // One clock: sample the grant at the negedge, then advance the model at
    // the posedge and return 1 time unit after that edge.
    task automatic step();
        @(negedge clk);
        exp_ack = model_grant();
        obs_ack = req_ack;
        @(posedge clk);
        model_edge(exp_ack);
        #1;
    endtask

    task automatic drain();
        req_stb = '0;
        res_ack = '1;
        repeat (LAT + 2) step();
        res_ack = '0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst     = 1'b1;
        req_stb = '1;
        for (int i = 0; i < NR; i++) req_a[i*64 +: 64] = rand_double();
        model_reset();
        step();
        n_checks++; if (obs_ack !== '0) begin n_errors++; $display("FAIL reset_ack: got %b expected 0", obs_ack); end
        n_checks++; if (res_stb !== '0) begin n_errors++; $display("FAIL reset_stb: got %b expected 0", res_stb); end
        n_checks++; if (res_z !== '0) begin n_errors++; $display("FAIL reset_z: got %h expected 0", res_z); end
        n_checks++; if (conv_a !== 64'd0) begin n_errors++; $display("FAIL reset_conv_a: got %h expected 0", conv_a); end
        n_checks++; if (dbg_state !== '0) begin n_errors++; $display("FAIL reset_state: got %h expected 0", dbg_state); end
        req_stb = '0;
        step();
        rst = 1'b0;
        step();
        n_checks++; if (res_stb !== '0) begin n_errors++; $display("FAIL post_reset_stb: got %b expected 0", res_stb); end
    endtask

    task automatic test_single();
        req_a[63:0] = 64'h4045000000000000;
        req_stb     = 4'b0001;
        step();                                   // edge 1
        n_checks++; if (obs_ack !== 4'b0001) begin n_errors++; $display("FAIL single_ack: got %b expected 0001", obs_ack); end
        n_checks++; if (conv_a !== 64'h4045000000000000) begin n_errors++; $display("FAIL single_conv_a: got %h expected 4045000000000000", conv_a); end
        req_stb = '0;
        repeat (LAT - 1) step();                  // edges 2..4
        n_checks++; if (res_stb !== 4'b0000) begin n_errors++; $display("FAIL single_early: got %b expected 0000", res_stb); end
        step();                                   // edge 5
        n_checks++; if (res_stb !== 4'b0001) begin n_errors++; $display("FAIL single_stb: got %b expected 0001", res_stb); end
        n_checks++; if (res_z[63:0] !== 64'd42) begin n_errors++; $display("FAIL single_z: got %h expected 42", res_z[63:0]); end
        step();                                   // edge 6
        n_checks++; if (res_stb !== 4'b0001) begin n_errors++; $display("FAIL single_hold: got %b expected 0001", res_stb); end
        res_ack = 4'b0001;
        step();                                   // edge 7
        res_ack = '0;
        n_checks++; if (res_stb !== 4'b0000) begin n_errors++; $display("FAIL single_acked: got %b expected 0000", res_stb); end
        n_checks++; if (res_z[63:0] !== 64'd42) begin n_errors++; $display("FAIL single_retained: got %h expected 42", res_z[63:0]); end
    endtask

    task automatic test_all_four();
        logic [63:0] ops [NR];
        rst = 1'b1;
        model_reset();
        step();
        rst = 1'b0;
        for (int i = 0; i < NR; i++) begin
            ops[i] = rand_double();
            req_a[i*64 +: 64] = ops[i];
        end
        req_stb = '1;
        for (int e = 0; e < NR; e++) begin
            step();
            n_checks++; if (obs_ack !== 4'(1 << e)) begin n_errors++; $display("FAIL all4_grant %0d: got %b expected %b", e, obs_ack, 4'(1 << e)); end
        end
        for (int e = 1; e <= NR; e++) begin
            step();
            n_checks++; if (obs_ack !== '0) begin n_errors++; $display("FAIL all4_no_grant %0d: got %b expected 0", e, obs_ack); end
            n_checks++; if (res_stb !== 4'((1 << e) - 1)) begin n_errors++; $display("FAIL all4_stb %0d: got %b expected %b", e, res_stb, 4'((1 << e) - 1)); end
        end
        for (int i = 0; i < NR; i++) begin
            n_checks++; if (res_z[i*64 +: 64] !== d2i(ops[i])) begin n_errors++; $display("FAIL all4_z %0d: got %h expected %h", i, res_z[i*64 +: 64], d2i(ops[i])); end
        end
        req_stb = '0;
        res_ack = '1;
        step();
        res_ack = '0;
        n_checks++; if (res_stb !== '0) begin n_errors++; $display("FAIL all4_acked: got %b expected 0", res_stb); end
    endtask

    task automatic test_negative();
        req_a[191:128] = 64'hC000000000000000;
        req_stb        = 4'b0100;
        step();
        n_checks++; if (obs_ack !== 4'b0100) begin n_errors++; $display("FAIL neg_ack: got %b expected 0100", obs_ack); end
        req_stb = '0;
        repeat (LAT) step();
        n_checks++; if (res_stb !== 4'b0100) begin n_errors++; $display("FAIL neg_stb: got %b expected 0100", res_stb); end
        n_checks++; if (res_z[191:128] !== 64'hFFFFFFFFFFFFFFFE) begin n_errors++; $display("FAIL neg_z: got %h expected fffffffffffffffe", res_z[191:128]); end
        drain();
    endtask

    task automatic test_ack_same_edge();
        logic [63:0] op2;
        req_a[63:0] = rand_double();
        req_stb     = 4'b0001;
        step();
        req_stb = '0;
        repeat (LAT) step();
        n_checks++; if (res_stb[0] !== 1'b1) begin n_errors++; $display("FAIL same_edge_done: got %b expected 1", res_stb[0]); end
        op2         = rand_double();
        req_a[63:0] = op2;
        res_ack     = 4'b0001;
        req_stb     = 4'b0001;
        step();
        n_checks++; if (obs_ack[0] !== 1'b0) begin n_errors++; $display("FAIL same_edge_ack: got %b expected 0", obs_ack[0]); end
        res_ack = '0;
        step();
        n_checks++; if (obs_ack[0] !== 1'b1) begin n_errors++; $display("FAIL next_edge_ack: got %b expected 1", obs_ack[0]); end
        req_stb = '0;
        repeat (LAT) step();
        n_checks++; if (res_z[63:0] !== d2i(op2)) begin n_errors++; $display("FAIL same_edge_z: got %h expected %h", res_z[63:0], d2i(op2)); end
        drain();
    endtask

    task automatic test_hold();
        logic [63:0] op1;
        logic [63:0] hold_val;
        op1          = rand_double();
        hold_val     = d2i(op1);
        req_a[127:64] = op1;
        req_stb      = 4'b0010;
        for (int w = 0; w < 10 && m_st[1] != 2; w++) step();
        n_checks++; if (res_stb[1] !== 1'b1) begin n_errors++; $display("FAIL hold_done: got %b expected 1", res_stb[1]); end
        for (int c = 0; c < 20; c++) begin
            req_stb        = 4'b1010;
            res_ack        = {(m_st[3] == 2), 3'b000};
            req_a[255:192] = rand_double();
            step();
            n_checks++; if (obs_ack !== exp_ack) begin n_errors++; $display("FAIL hold_ack %0d: got %b expected %b", c, obs_ack, exp_ack); end
            n_checks++; if (obs_ack[1] !== 1'b0) begin n_errors++; $display("FAIL hold_no_grant1 %0d: got %b expected 0", c, obs_ack[1]); end
            n_checks++; if (res_z[127:64] !== hold_val) begin n_errors++; $display("FAIL hold_z1 %0d: got %h expected %h", c, res_z[127:64], hold_val); end
            n_checks++; if (res_stb !== exp_stb()) begin n_errors++; $display("FAIL hold_stb %0d: got %b expected %b", c, res_stb, exp_stb()); end
            n_checks++; if (res_z !== exp_z()) begin n_errors++; $display("FAIL hold_z %0d: got %h expected %h", c, res_z, exp_z()); end
        end
        drain();
    endtask

    task automatic test_reset_midflight();
        logic [63:0] op;
        for (int i = 0; i < 3; i++) req_a[i*64 +: 64] = rand_double();
        req_stb = 4'b0111;
        repeat (3) step();
        rst     = 1'b1;
        req_stb = '0;
        model_reset();
        step();
        n_checks++; if (obs_ack !== '0) begin n_errors++; $display("FAIL rst_flight_ack: got %b expected 0", obs_ack); end
        rst = 1'b0;
        for (int c = 0; c < LAT + 2; c++) begin
            step();
            n_checks++; if (res_stb !== '0) begin n_errors++; $display("FAIL rst_flight_stb %0d: got %b expected 0", c, res_stb); end
        end
        op            = rand_double();
        req_a[127:64] = op;
        req_stb       = 4'b0010;
        step();
        n_checks++; if (obs_ack !== 4'b0010) begin n_errors++; $display("FAIL rst_new_ack: got %b expected 0010", obs_ack); end
        req_stb = '0;
        repeat (LAT - 1) step();
        n_checks++; if (res_stb !== '0) begin n_errors++; $display("FAIL rst_new_early: got %b expected 0", res_stb); end
        step();
        n_checks++; if (res_stb !== 4'b0010) begin n_errors++; $display("FAIL rst_new_stb: got %b expected 0010", res_stb); end
        n_checks++; if (res_z[127:64] !== d2i(op)) begin n_errors++; $display("FAIL rst_new_z: got %h expected %h", res_z[127:64], d2i(op)); end
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++) begin
                req_stb[i] = ($urandom_range(0, 9) < 6);
                res_ack[i] = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) req_a[i*64 +: 64] = rand_double();
            end
            step();
            n_checks++; if (obs_ack !== exp_ack) begin n_errors++; $display("FAIL rand_ack %0d: got %b expected %b", c, obs_ack, exp_ack); end
            n_checks++; if (res_stb !== exp_stb()) begin n_errors++; $display("FAIL rand_stb %0d: got %b expected %b", c, res_stb, exp_stb()); end
            n_checks++; if (res_z !== exp_z()) begin n_errors++; $display("FAIL rand_z %0d: got %h expected %h", c, res_z, exp_z()); end
            n_checks++; if (conv_a !== m_conv_a) begin n_errors++; $display("FAIL rand_conv_a %0d: got %h expected %h", c, conv_a, m_conv_a); end
        end
        drain();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_negative();
        test_ack_same_edge();
        test_hold();
        test_reset_midflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
